// File: rtl/md_pkg.sv
// Shared MD-simulator types: particle record width/type and exit-arbiter FSM states.
package md_pkg;

  localparam int unsigned PARTICLE_W = 96;

  typedef logic [PARTICLE_W-1:0] particle_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } arb_state_t;

endpackage

// File: rtl/cell_exit_arbiter_rr_pick2.sv
// rr_pick2: combinational two-winner wrapping priority search.
// idx0 = first requester at index >= ptr (wrapping); idx1 = next requester after idx0.
module rr_pick2 #(
  parameter int unsigned N_CELL = 27,
  parameter int unsigned PTR_W  = 5
) (
  input  logic [N_CELL-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [PTR_W-1:0]  idx0,
  output logic              v0,
  output logic [PTR_W-1:0]  idx1,
  output logic              v1
);

  int unsigned j;
  int unsigned first;

  // Two sequential wrapping scans: the second starts one past the first winner.
  always_comb begin
    idx0  = '0;
    v0    = 1'b0;
    idx1  = '0;
    v1    = 1'b0;
    j     = 0;
    first = 0;
    for (int unsigned i = 0; i < N_CELL; i++) begin
      j = 32'(ptr) + i;
      if (j >= N_CELL) j = j - N_CELL;
      if (!v0 && req[j[PTR_W-1:0]]) begin
        v0    = 1'b1;
        idx0  = PTR_W'(j);
        first = j;
      end
    end
    for (int unsigned i = 1; i < N_CELL; i++) begin
      j = first + i;
      if (j >= N_CELL) j = j - N_CELL;
      if (v0 && !v1 && req[j[PTR_W-1:0]]) begin
        v1   = 1'b1;
        idx1 = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/cell_exit_arbiter.sv
// cell_exit_arbiter: round-robin two-lane arbiter packing cell records into exit-FIFO pair words,
// with a drain sequence for the dump phase.
// Optional statistics counters are enabled by defining CELL_EXIT_ARB_STATS_EN.
module cell_exit_arbiter
  import md_pkg::*;
#(
  parameter int unsigned N_CELL = 27,
  parameter int unsigned DATA_W = PARTICLE_W,
  parameter int unsigned PTR_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_run,
  input  logic                     i_drain,
  input  logic [N_CELL-1:0]        i_req,
  input  logic [N_CELL*DATA_W-1:0] i_data,
  output logic [N_CELL-1:0]        o_grant,
  output logic [1:0]               o_pair_valid,
  output logic [2*DATA_W-1:0]      o_pair_data,
  input  logic                     i_fifo_ready,
  output logic                     o_drain_done,
  output logic                     o_busy
`ifdef CELL_EXIT_ARB_STATS_EN
  ,
  output logic [31:0]              o_words_out,
  output logic [31:0]              o_stall_cycles,
  output logic [31:0]              o_single_words
`endif
);

  arb_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [PTR_W-1:0]  last_idx;
  logic              drain_armed;
  logic [PTR_W-1:0]  idx0;
  logic [PTR_W-1:0]  idx1;
  logic              v0;
  logic              v1;
  logic              load;
  logic              grant_en;
  logic              xfer;
  logic              drain_req;
  logic [DATA_W-1:0] cell_rec [N_CELL];

  for (genvar g = 0; g < N_CELL; g++) begin : g_unpack
    assign cell_rec[g] = i_data[g*DATA_W +: DATA_W];
  end

  rr_pick2 #(
    .N_CELL (N_CELL),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req  (i_req),
    .ptr  (ptr),
    .idx0 (idx0),
    .v0   (v0),
    .idx1 (idx1),
    .v1   (v1)
  );

  // Load/transfer qualifiers, grant vector and next round-robin pointer.
  always_comb begin
    load      = ~(|o_pair_valid) | i_fifo_ready;
    xfer      = (|o_pair_valid) & i_fifo_ready;
    grant_en  = load & ((state == RUN) | (state == DRAIN)) & ~rst;
    drain_req = i_drain & drain_armed;
    o_grant   = '0;
    if (grant_en) begin
      if (v0) o_grant[idx0] = 1'b1;
      if (v1) o_grant[idx1] = 1'b1;
    end
    last_idx = v1 ? idx1 : idx0;
    ptr_nxt  = (32'(last_idx) == N_CELL - 1) ? '0 : last_idx + 1'b1;
  end

  // Output register: reloads only when empty or being accepted; otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pair_valid <= '0;
      o_pair_data  <= '0;
      ptr          <= '0;
    end else if (load) begin
      o_pair_valid <= {grant_en & v1, grant_en & v0};
      o_pair_data  <= {(grant_en & v1) ? cell_rec[idx1] : '0,
                       (grant_en & v0) ? cell_rec[idx0] : '0};
      if (grant_en && v0) ptr <= ptr_nxt;
    end
  end

  // Phase FSM; a new drain needs i_drain to have dropped since the previous one was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      o_drain_done <= 1'b0;
      o_busy       <= 1'b0;
      drain_armed  <= 1'b1;
    end else begin
      o_drain_done <= 1'b0;
      if (!i_drain) drain_armed <= 1'b1;
      case (state)
        IDLE: begin
          if (drain_req) begin
            state       <= DRAIN;
            o_busy      <= 1'b1;
            drain_armed <= 1'b0;
          end else if (i_run) begin
            state  <= RUN;
            o_busy <= 1'b1;
          end
        end
        RUN: begin
          if (drain_req) begin
            state       <= DRAIN;
            drain_armed <= 1'b0;
          end else if (!i_run) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        DRAIN: begin
          if ((i_req == '0) && (~(|o_pair_valid) || i_fifo_ready)) begin
            state        <= DONE;
            o_drain_done <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef CELL_EXIT_ARB_STATS_EN
  logic enter_drain;

  always_comb begin
    enter_drain = drain_req & ((state == IDLE) | (state == RUN));
  end

  // Saturating traffic counters, cleared at reset and whenever a drain begins.
  always_ff @(posedge clk) begin
    if (rst || enter_drain) begin
      o_words_out    <= '0;
      o_stall_cycles <= '0;
      o_single_words <= '0;
    end else begin
      if (xfer && (o_words_out != '1)) o_words_out <= o_words_out + 1'b1;
      if ((|o_pair_valid) && !i_fifo_ready && (o_stall_cycles != '1))
        o_stall_cycles <= o_stall_cycles + 1'b1;
      if (xfer && (o_pair_valid == 2'b01) && (o_single_words != '1))
        o_single_words <= o_single_words + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cell_exit_arbiter.sv
// Scoreboard bench for cell_exit_arbiter: directed stimulus pushes expected pair words,
// an independent monitor pops and compares on every transfer.
module tb_cell_exit_arbiter;
  import md_pkg::*;

  localparam int unsigned N = 27;
  localparam int unsigned W = 96;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_run = 1'b0;
  logic           i_drain = 1'b0;
  logic [N-1:0]   i_req = '0;
  logic [N*W-1:0] i_data = '0;
  logic [N-1:0]   o_grant;
  logic [1:0]     o_pair_valid;
  logic [2*W-1:0] o_pair_data;
  logic           i_fifo_ready = 1'b1;
  logic           o_drain_done;
  logic           o_busy;
`ifdef CELL_EXIT_ARB_STATS_EN
  logic [31:0]    o_words_out;
  logic [31:0]    o_stall_cycles;
  logic [31:0]    o_single_words;
`endif

  typedef struct {
    logic [1:0]  v;
    int unsigned c0;
    int unsigned c1;
  } exp_t;

  exp_t           sbq[$];
  int             checks = 0;
  int             errors = 0;
  int unsigned    cyc = 0;
  logic           pop_en = 1'b1;
  logic [N-1:0]   g_s;
  logic           xfer_s, done_s, busy_s;
  logic [1:0]     v_s;
  logic [2*W-1:0] d_s;

  cell_exit_arbiter #(.N_CELL(N), .DATA_W(W), .PTR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_run        (i_run),
    .i_drain      (i_drain),
    .i_req        (i_req),
    .i_data       (i_data),
    .o_grant      (o_grant),
    .o_pair_valid (o_pair_valid),
    .o_pair_data  (o_pair_data),
    .i_fifo_ready (i_fifo_ready),
    .o_drain_done (o_drain_done),
    .o_busy       (o_busy)
`ifdef CELL_EXIT_ARB_STATS_EN
    ,
    .o_words_out    (o_words_out),
    .o_stall_cycles (o_stall_cycles),
    .o_single_words (o_single_words)
`endif
  );

  always #5 clk = ~clk;

  function automatic particle_t rec(int unsigned k);
    return {32'hC0DE_0000 + k, 32'(k * 7 + 3), 32'hA5A5_0100 + k};
  endfunction

  function automatic logic [2*W-1:0] exp_data(exp_t e);
    logic [W-1:0] l1;
    l1 = e.v[1] ? rec(e.c1) : '0;
    return {l1, rec(e.c0)};
  endfunction

  function automatic exp_t mk(logic [1:0] v, int unsigned c0, int unsigned c1);
    exp_t e;
    e.v  = v;
    e.c0 = c0;
    e.c1 = c1;
    return e;
  endfunction

  // Monitor: every accepted word must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (|o_pair_valid) && i_fifo_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected got v=%b d=%h", o_pair_valid, o_pair_data);
        end else begin
          e = sbq.pop_front();
          if ({o_pair_valid, o_pair_data} !== {e.v, exp_data(e)}) begin
            errors++;
            $display("FAIL word c0=%0d c1=%0d got v=%b d=%h expected v=%b d=%h",
                     e.c0, e.c1, o_pair_valid, o_pair_data, e.v, exp_data(e));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    g_s    = o_grant;
    xfer_s = (|o_pair_valid) && i_fifo_ready;
    v_s    = o_pair_valid;
    d_s    = o_pair_data;
    done_s = o_drain_done;
    busy_s = o_busy;
    @(posedge clk);
    #1;
    if (pop_en) i_req = i_req & ~g_s;
    cyc++;
  endtask

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; i_run = 1'b0; i_drain = 1'b0; i_req = '0; i_fifo_ready = 1'b1; pop_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_empty(string nm, int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, sbq.size(), 0);
  endtask

  task automatic wait_grant(string nm, int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (g_s == '0 && n < budget);
    chk(nm, (g_s != '0), 1);
  endtask

  initial begin : stim
    int          n, ngr, last_x, done_cnt, done_c, busy_fall;
    logic        busy_prev, saw_busy;
    exp_t        e4;
    logic [N-1:0] gv;

    for (int unsigned k = 0; k < N; k++) i_data[k*W +: W] = rec(k);

    // Reset state, with requests and run present during reset.
    i_req = '1; i_run = 1'b1;
    tick();
    chk("rst_grant", g_s, 0);
    chk("rst_valid", v_s, 0);
    chk("rst_data", d_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_busy", busy_s, 0);

    // T1: cells 0 and 2 -> one two-lane word; ptr lands on 3 (checked via wrap order).
    do_reset();
    i_run = 1'b1; i_req = 27'h0000005;
    sbq.push_back(mk(2'b11, 0, 2));
    wait_grant("t1_grant_seen", 10);
    gv = 27'h0000005;
    chk("t1_grant", g_s, gv);
    tick();
    chk("t1_valid", v_s, 2'b11);
    chk("t1_busy", busy_s, 1);
    i_req = 27'b1010;
    sbq.push_back(mk(2'b11, 3, 1));
    wait_empty("t1_ptr3_order", 10);

    // T2: move ptr to 26, then {26,0,1} wraps, cell1 alone afterwards.
    do_reset();
    i_run = 1'b1; i_req = 27'd1 << 25;
    sbq.push_back(mk(2'b01, 25, 0));
    wait_empty("t2_setup", 10);
    i_req = (27'd1 << 26) | 27'd3;
    sbq.push_back(mk(2'b11, 26, 0));
    sbq.push_back(mk(2'b01, 1, 0));
    wait_empty("t2_wrap", 10);

    // T3a: all 27 request once -> 13 pairs then cell 26 alone.
    do_reset();
    i_run = 1'b1; i_req = '1;
    for (int unsigned w = 0; w < 13; w++) sbq.push_back(mk(2'b11, 2*w, 2*w + 1));
    sbq.push_back(mk(2'b01, 26, 0));
    wait_empty("t3a_rotation", 30);
    chk("t3a_all_popped", i_req, 0);
`ifdef CELL_EXIT_ARB_STATS_EN
    chk("t3a_words_out", o_words_out, 14);
    chk("t3a_single", o_single_words, 1);
`endif

    // T3b: all 27 requesting continuously -> two grants every load, wrapping.
    do_reset();
    pop_en = 1'b0; i_run = 1'b1; i_req = '1;
    for (int unsigned w = 0; w < 20; w++) sbq.push_back(mk(2'b11, (2*w) % N, (2*w + 1) % N));
    ngr = 0; n = 0;
    while (ngr < 20 && n < 60) begin
      tick();
      n++;
      if (g_s != '0) begin
        ngr++;
        chk("t3b_twohot", $countones(g_s), 2);
      end
    end
    i_req = '0; pop_en = 1'b1;
    chk("t3b_grant_count", ngr, 20);
    wait_empty("t3b_words", 10);

    // T4: stall for 5 cycles with a pending requester; grants frozen, data held.
    do_reset();
    i_run = 1'b1; i_req = (27'd1 << 4) | (27'd1 << 9);
    sbq.push_back(mk(2'b11, 4, 9));
    wait_grant("t4_grant_seen", 10);
    i_fifo_ready = 1'b0; i_req = 27'd1 << 7;
    sbq.push_back(mk(2'b01, 7, 0));
    e4 = mk(2'b11, 4, 9);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_grant_frozen", g_s, 0);
      chk("t4_hold", {v_s, d_s}, {2'b11, exp_data(e4)});
    end
`ifdef CELL_EXIT_ARB_STATS_EN
    chk("t4_stalls", o_stall_cycles, 5);
`endif
    i_fifo_ready = 1'b1;
    wait_empty("t4_release", 10);

    // T5: drain with 7 cells pending; i_drain held high afterwards must not re-trigger.
    do_reset();
    i_drain = 1'b1;
    i_req = (27'd1 << 0) | (27'd1 << 3) | (27'd1 << 5) | (27'd1 << 8) |
            (27'd1 << 13) | (27'd1 << 20) | (27'd1 << 26);
    sbq.push_back(mk(2'b11, 0, 3));
    sbq.push_back(mk(2'b11, 5, 8));
    sbq.push_back(mk(2'b11, 13, 20));
    sbq.push_back(mk(2'b01, 26, 0));
    last_x = -1; done_cnt = 0; done_c = -1; busy_fall = -1; busy_prev = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (xfer_s) last_x = int'(cyc);
      if (done_s) begin
        done_cnt++;
        done_c = int'(cyc);
      end
      if (busy_s) saw_busy = 1'b1;
      if (busy_prev && !busy_s && busy_fall < 0) busy_fall = int'(cyc);
      busy_prev = busy_s;
    end
    chk("t5_words", sbq.size(), 0);
    chk("t5_busy_rose", saw_busy, 1);
    chk("t5_done_once", done_cnt, 1);
    chk("t5_done_after_last", done_c, last_x + 1);
    chk("t5_busy_fall", busy_fall, done_c + 1);
    chk("t5_no_redrain", busy_s, 0);
    i_drain = 1'b0;

    // T6: reset while a word is held under back-pressure; the word is discarded.
    do_reset();
    i_run = 1'b1; i_req = (27'd1 << 11) | (27'd1 << 12);
    wait_grant("t6_grant_seen", 10);
    i_fifo_ready = 1'b0; i_req = 27'd1 << 5;
    tick();
    tick();
    chk("t6_held", v_s, 2'b11);
    rst = 1'b1;
    tick();
    chk("t6_grant_in_rst", g_s, 0);
    tick();
    chk("t6_valid_cleared", v_s, 0);
    chk("t6_grant_cleared", g_s, 0);
    chk("t6_busy_idle", busy_s, 0);
`ifdef CELL_EXIT_ARB_STATS_EN
    chk("t6_words_zero", o_words_out, 0);
    chk("t6_stall_zero", o_stall_cycles, 0);
    chk("t6_single_zero", o_single_words, 0);
`endif
    rst = 1'b0; i_run = 1'b0; i_req = '0; i_fifo_ready = 1'b1;
    tick();
    chk("t6_idle_no_grant", g_s, 0);

    chk("final_queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
